// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller with one word per line.
// A two-process FSM handles lookup, write-back of a dirty victim, refill and completion.
module cache_ctrl #(
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 8,
   parameter int INDEX_W = 2
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_busy,
   output logic              cpu_done,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_hit,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [7:0]        hit_count,
   output logic [7:0]        miss_count
);
   localparam int TAG_W = ADDR_W - INDEX_W;
   localparam int LINES = 2**INDEX_W;

   typedef enum logic [2:0] {
      S_IDLE, S_COMPARE, S_WRITEBACK, S_ALLOCATE, S_DONE
   } state_t;

   state_t              r_state, w_next;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_we;
   logic                r_miss;
   logic [LINES-1:0]    r_valid;
   logic [LINES-1:0]    r_dirty;
   logic [TAG_W-1:0]    r_tag  [LINES];
   logic [DATA_W-1:0]   r_data [LINES];
   logic [DATA_W-1:0]   r_rdata;
   logic [7:0]          r_hit_count;
   logic [7:0]          r_miss_count;

   logic [INDEX_W-1:0]  w_idx;
   logic [TAG_W-1:0]    w_tag;
   logic                w_hit;

   assign w_idx = r_addr[INDEX_W-1:0];
   assign w_tag = r_addr[ADDR_W-1:INDEX_W];
   assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

   assign cpu_rdata  = r_rdata;
   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;

   // NOTE: every output and w_next gets a default first so no path infers a latch.
   always_comb begin
      w_next    = r_state;
      cpu_busy  = (r_state != S_IDLE);
      cpu_done  = 1'b0;
      cpu_hit   = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (r_state)
         S_IDLE:
            if (cpu_req) w_next = S_COMPARE;
         S_COMPARE:
            if (w_hit)                                w_next = S_DONE;
            else if (r_valid[w_idx] && r_dirty[w_idx]) w_next = S_WRITEBACK;
            else                                      w_next = S_ALLOCATE;
         S_WRITEBACK: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {r_tag[w_idx], w_idx};
            mem_wdata = r_data[w_idx];
            if (mem_ready) w_next = S_ALLOCATE;
         end
         S_ALLOCATE: begin
            mem_req  = 1'b1;
            mem_addr = r_addr;
            if (mem_ready) w_next = S_COMPARE;
         end
         S_DONE: begin
            cpu_done = 1'b1;
            cpu_hit  = !r_miss;
            w_next   = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_we         <= 1'b0;
         r_miss       <= 1'b0;
         r_valid      <= '0;
         r_dirty      <= '0;
         r_rdata      <= '0;
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE:
               if (cpu_req) begin
                  r_addr  <= cpu_addr;
                  r_wdata <= cpu_wdata;
                  r_we    <= cpu_we;
                  r_miss  <= 1'b0;
               end
            S_COMPARE:
               if (!w_hit) r_miss <= 1'b1;
               else if (r_we) begin
                  r_dirty[w_idx] <= 1'b1;
                  r_rdata        <= r_wdata;
               end else r_rdata <= r_data[w_idx];
            S_WRITEBACK:
               if (mem_ready) r_dirty[w_idx] <= 1'b0;
            S_ALLOCATE:
               if (mem_ready) begin
                  r_valid[w_idx] <= 1'b1;
                  r_dirty[w_idx] <= 1'b0;
               end
            S_DONE:
               if (r_miss) r_miss_count <= r_miss_count + 8'd1;
               else        r_hit_count  <= r_hit_count + 8'd1;
            default: ;
         endcase
      end
   end

   // NOTE: line storage has no reset; the cleared valid bits gate every lookup.
   always_ff @(posedge CLOCK_50) begin
      if (r_state == S_COMPARE && w_hit && r_we) begin
         r_data[w_idx] <= r_wdata;
      end else if (r_state == S_ALLOCATE && mem_ready) begin
         r_data[w_idx] <= mem_rdata;
         r_tag[w_idx]  <= w_tag;
      end
   end
endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: a RAM responder with programmable wait plus a
// line-level cache model predicting hit, data, memory traffic, latency and counters.
module tb_cache_ctrl;
   typedef struct packed {
      logic       we;
      logic [4:0] addr;
      logic [7:0] wdata;
   } acc_t;

   logic       CLOCK_50 = 1'b0;
   logic       reset    = 1'b0;
   logic       cpu_req  = 1'b0;
   logic       cpu_we   = 1'b0;
   logic [4:0] cpu_addr = '0;
   logic [7:0] cpu_wdata = '0;
   logic       cpu_busy, cpu_done, cpu_hit;
   logic [7:0] cpu_rdata;
   logic       mem_req, mem_we;
   logic [4:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata = '0;
   logic       mem_ready = 1'b0;
   logic [7:0] hit_count, miss_count;

   cache_ctrl #(.ADDR_W(5), .DATA_W(8), .INDEX_W(2)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int         n_cmp = 0;
   int         n_err = 0;
   int         mem_wait_cfg = 1;
   int         wait_cnt = 0;
   int         done_cnt = 0;
   logic [7:0] ram [32];
   acc_t       acc_log [$];

   // Reference model: line contents, expected memory image and expected counters.
   logic       m_valid [4];
   logic       m_dirty [4];
   logic [2:0] m_tag   [4];
   logic [7:0] m_data  [4];
   logic [7:0] m_ram   [32];
   logic [7:0] m_hits, m_misses;

   // RAM responder: answers each access after mem_wait_cfg idle cycles, ready for one cycle.
   always @(negedge CLOCK_50) begin
      if (cpu_done) done_cnt++;
      mem_ready = 1'b0;
      if (!mem_req) wait_cnt = 0;
      else if (wait_cnt >= mem_wait_cfg) begin
         mem_ready = 1'b1;
         wait_cnt  = 0;
         mem_rdata = ram[mem_addr];
         if (mem_we) ram[mem_addr] = mem_wdata;
         acc_log.push_back({mem_we, mem_addr, mem_wdata});
      end else wait_cnt++;
   end

   task automatic step();
      @(negedge CLOCK_50);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      m_hits   = '0;
      m_misses = '0;
   endtask

   task automatic do_req(input logic we, input logic [4:0] addr, input logic [7:0] wdata,
                         input int pulse_at, input string name);
      logic [1:0] idx;
      logic [2:0] tg;
      logic       exp_hit, hit, got, prev_req, prev_ready;
      logic [7:0] exp_rdata, rd;
      acc_t       prev_bus;
      acc_t       exp_acc [$];
      int         exp_lat, lat, glitch, busy_bad, req_cycles, d0, acc_bad;

      idx     = addr[1:0];
      tg      = addr[4:2];
      exp_hit = m_valid[idx] && (m_tag[idx] == tg);
      exp_lat = 2;
      if (!exp_hit) begin
         if (m_valid[idx] && m_dirty[idx]) begin
            exp_acc.push_back({1'b1, m_tag[idx], idx, m_data[idx]});
            m_ram[{m_tag[idx], idx}] = m_data[idx];
            exp_lat += mem_wait_cfg + 1;
         end
         exp_acc.push_back({1'b0, addr, 8'h00});
         exp_lat += mem_wait_cfg + 2;
         m_valid[idx] = 1'b1;
         m_dirty[idx] = 1'b0;
         m_tag[idx]   = tg;
         m_data[idx]  = m_ram[addr];
      end
      if (we) begin
         m_data[idx]  = wdata;
         m_dirty[idx] = 1'b1;
      end
      exp_rdata = m_data[idx];
      if (exp_hit) m_hits++;
      else         m_misses++;

      acc_log.delete();
      d0 = done_cnt;
      // NOTE: inputs are driven with blocking assignments half a cycle away from the clock edge.
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      lat = 0; got = 1'b0; glitch = 0; busy_bad = 0; req_cycles = 0;
      prev_req = 1'b0; prev_ready = 1'b0; prev_bus = '0; hit = 1'b0; rd = '0;
      while (!got && lat < 200) begin
         step();
         lat++;
         if (lat == 1) begin
            cpu_req   = 1'b0;
            cpu_we    = 1'($urandom);
            cpu_addr  = 5'($urandom);
            cpu_wdata = 8'($urandom);
         end
         if (lat == pulse_at)          cpu_req = 1'b1;
         else if (lat == pulse_at + 1) cpu_req = 1'b0;
         if (mem_req) req_cycles++;
         if (cpu_done) begin
            got = 1'b1;
            rd  = cpu_rdata;
            hit = cpu_hit;
         end else begin
            if (!cpu_busy) busy_bad++;
            if (mem_req && prev_req && !prev_ready && {mem_we, mem_addr, mem_wdata} !== prev_bus)
               glitch++;
         end
         prev_req   = mem_req;
         prev_ready = mem_ready;
         prev_bus   = {mem_we, mem_addr, mem_wdata};
      end

      n_cmp++;
      if (!got) begin
         n_err++;
         $display("FAIL %s timeout: no cpu_done after %0d cycles, required within %0d", name, lat, exp_lat);
         return;
      end
      n_cmp++; if (hit !== exp_hit) begin n_err++; $display("FAIL %s hit: got %0b want %0b", name, hit, exp_hit); end
      n_cmp++; if (rd !== exp_rdata) begin n_err++; $display("FAIL %s rdata: got %02h want %02h", name, rd, exp_rdata); end
      n_cmp++; if (lat != exp_lat) begin n_err++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat); end
      n_cmp++; if (req_cycles != exp_acc.size() * (mem_wait_cfg + 1)) begin n_err++;
         $display("FAIL %s mem_req cycles: got %0d want %0d", name, req_cycles, exp_acc.size() * (mem_wait_cfg + 1)); end
      acc_bad = 0;
      if (acc_log.size() != exp_acc.size()) acc_bad = 1;
      else foreach (exp_acc[i])
         if (acc_log[i].we !== exp_acc[i].we || acc_log[i].addr !== exp_acc[i].addr ||
             (exp_acc[i].we && acc_log[i].wdata !== exp_acc[i].wdata)) acc_bad++;
      n_cmp++; if (acc_bad != 0) begin n_err++;
         $display("FAIL %s mem accesses: got %0d (first %h) want %0d (first %h)", name, acc_log.size(),
                  (acc_log.size() > 0) ? acc_log[0] : '0, exp_acc.size(), exp_acc[0]); end
      n_cmp++; if (glitch != 0 || busy_bad != 0) begin n_err++;
         $display("FAIL %s stability: got %0d bus changes %0d idle-while-busy, want 0 0", name, glitch, busy_bad); end
      step();
      n_cmp++; if (cpu_busy !== 1'b0 || cpu_done !== 1'b0) begin n_err++;
         $display("FAIL %s after done: got busy %0b done %0b want 0 0", name, cpu_busy, cpu_done); end
      n_cmp++; if (cpu_rdata !== exp_rdata) begin n_err++; $display("FAIL %s rdata hold: got %02h want %02h", name, cpu_rdata, exp_rdata); end
      n_cmp++; if (hit_count !== m_hits || miss_count !== m_misses) begin n_err++;
         $display("FAIL %s counters: got %0d/%0d want %0d/%0d", name, hit_count, miss_count, m_hits, m_misses); end
      n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL %s done pulses: got %0d want 1", name, done_cnt - d0); end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 32; i++) begin
         ram[i]   = 8'($urandom);
         m_ram[i] = ram[i];
      end
      ram[5] = 8'hA5; m_ram[5] = 8'hA5;
      model_reset();
      reset = 1'b0;
      step(); step();
      n_cmp++;
      if ({cpu_busy, cpu_done, cpu_hit, mem_req, mem_we} !== 5'b0 || cpu_rdata !== 8'h00 ||
          mem_addr !== 5'h00 || mem_wdata !== 8'h00 || hit_count !== 8'h00 || miss_count !== 8'h00) begin
         n_err++;
         $display("FAIL reset outputs: got busy%0b done%0b hit%0b req%0b we%0b rd%02h ma%02h mw%02h hc%0d mc%0d want all 0",
                  cpu_busy, cpu_done, cpu_hit, mem_req, mem_we, cpu_rdata, mem_addr, mem_wdata, hit_count, miss_count);
      end
      reset = 1'b1;
      step();
      n_cmp++; if (cpu_busy !== 1'b0) begin n_err++; $display("FAIL reset release busy: got %0b want 0", cpu_busy); end
   endtask

   task automatic test_directed();
      mem_wait_cfg = 1;
      do_req(1'b0, 5'h05, 8'h00, -1, "cold_read_05");
      do_req(1'b0, 5'h05, 8'h00, -1, "hit_read_05");
      do_req(1'b1, 5'h05, 8'h3C, -1, "hit_write_05");
      do_req(1'b0, 5'h0D, 8'h00, -1, "dirty_miss_0d");
   endtask

   task automatic test_stall();
      mem_wait_cfg = 10;
      do_req(1'b0, 5'h02, 8'h00, -1, "stall_refill_02");
      mem_wait_cfg = 1;
   endtask

   task automatic test_busy_ignore();
      int d0;
      mem_wait_cfg = 3;
      d0 = done_cnt;
      do_req(1'b0, 5'h1B, 8'h00, 2, "busy_pulse_1b");
      repeat (4) step();
      n_cmp++; if (done_cnt - d0 != 1 || cpu_busy !== 1'b0) begin n_err++;
         $display("FAIL busy_ignore: got %0d dones busy %0b want 1 dones busy 0", done_cnt - d0, cpu_busy); end
      mem_wait_cfg = 1;
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         mem_wait_cfg = int'($urandom_range(0, 3));
         do_req(1'($urandom), 5'($urandom), 8'($urandom),
                ($urandom_range(0, 3) == 0) ? 2 : -1, $sformatf("rand_%0d", n));
      end
      mem_wait_cfg = 1;
   endtask

   task automatic test_wrap();
      do_req(1'b0, 5'h07, 8'h00, -1, "wrap_prime");
      for (int n = 0; n < 258; n++) do_req(1'b0, 5'h07, 8'h00, -1, "wrap_hit");
   endtask

   task automatic test_reset_wb();
      int t;
      mem_wait_cfg = 1;
      do_req(1'b0, 5'h0D, 8'h00, -1, "rwb_fill_0d");
      do_req(1'b1, 5'h0D, 8'h77, -1, "rwb_dirty_0d");
      mem_wait_cfg = 30;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h15;
      t = 0;
      step();
      cpu_req = 1'b0;
      while (!(mem_req && mem_we) && t < 20) begin
         step();
         t++;
      end
      n_cmp++; if (!(mem_req && mem_we)) begin n_err++; $display("FAIL rwb enter: got req %0b we %0b want 1 1", mem_req, mem_we); end
      step(); step();
      #3 reset = 1'b0;
      #1;
      n_cmp++;
      if (mem_req !== 1'b0 || cpu_busy !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 5'h00 ||
          hit_count !== 8'h00 || miss_count !== 8'h00 || cpu_rdata !== 8'h00) begin
         n_err++;
         $display("FAIL rwb reset: got req%0b busy%0b we%0b ma%02h hc%0d mc%0d rd%02h want all 0",
                  mem_req, cpu_busy, mem_we, mem_addr, hit_count, miss_count, cpu_rdata);
      end
      model_reset();
      step();
      reset = 1'b1;
      mem_wait_cfg = 1;
      step();
      do_req(1'b0, 5'h05, 8'h00, -1, "post_reset_05");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stall();
      test_busy_ignore();
      test_random();
      test_wrap();
      test_reset_wb();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
